// File: rtl/id_regfile_scoreboard.sv
// id_regfile_scoreboard
//   Decode-stage register file with an integrated per-register write scoreboard.
//   Serves NUM_RD zero-latency source reads and accepts one write-back per cycle.
//   Each register keeps a saturating count of issued-but-not-retired writes;
//   hazard is raised while any valid source operand is still in flight.
//
// Optional feature: define REGFILE_BYPASS_EN for write-through reads and
//   hazard suppression when the current write-back retires the last pending write.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   freeze     pipeline stall, blocks issue
//   flush      branch flush, blocks issue this cycle
//   src_valid  per-port live source operand flag
//   rd_addr    source addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data    source data, port k at [k*DATA_W +: DATA_W] (combinational)
//   issue_en   decoded instruction writes a register
//   issue_dest destination of that instruction
//   wb_en      write-back strobe
//   wb_dest    write-back destination
//   wb_value   write-back data
//   hazard     stall request to IF/ID (combinational)
//   pend_full  issue_dest counter saturated (combinational)

module id_regfile_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned CNT_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     freeze,
  input  logic                     flush,
  input  logic [NUM_RD-1:0]        src_valid,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_dest,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_dest,
  input  logic [DATA_W-1:0]        wb_value,
  output logic                     hazard,
  output logic                     pend_full
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] regs     [NUM_REGS];
  logic [CNT_W-1:0]  pend_cnt [NUM_REGS];

  logic [NUM_RD-1:0]   src_hit;
  logic [CNT_W-1:0]    dest_cnt;
  logic                dest_in_range;
  logic                issue_ok;
  logic [NUM_REGS-1:0] wb_sel;
  logic [NUM_REGS-1:0] cnt_inc;
  logic [NUM_REGS-1:0] cnt_dec;

  // Source read ports: address decode by comparison so out-of-range addresses
  // naturally return zero data and a zero pending count.
  always_comb begin
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
    logic              in_range;
`ifdef REGFILE_BYPASS_EN
    logic              wb_match;
`endif
    rd_data = '0;
    src_hit = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      addr     = rd_addr[k*ADDR_W +: ADDR_W];
      data     = '0;
      cnt      = CNT_ZERO;
      in_range = 1'b0;
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        if (addr == ADDR_W'(r)) begin
          data     = regs[r];
          cnt      = pend_cnt[r];
          in_range = 1'b1;
        end
      end
`ifdef REGFILE_BYPASS_EN
      wb_match = wb_en && in_range && (wb_dest == addr);
      if (wb_match) begin
        data = wb_value;
      end
      // The retiring write-back of the last pending write satisfies the operand.
      src_hit[k] = src_valid[k] && in_range && (cnt != CNT_ZERO) &&
                   !(wb_match && (cnt == CNT_ONE));
`else
      src_hit[k] = src_valid[k] && in_range && (cnt != CNT_ZERO);
`endif
      rd_data[k*DATA_W +: DATA_W] = data;
    end
  end

  // Destination counter lookup for the issuing instruction.
  always_comb begin
    dest_cnt      = CNT_ZERO;
    dest_in_range = 1'b0;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      if (issue_dest == ADDR_W'(r)) begin
        dest_cnt      = pend_cnt[r];
        dest_in_range = 1'b1;
      end
    end
  end

  assign pend_full = issue_en && (dest_cnt == CNT_MAX);
  assign hazard    = (|src_hit) || pend_full;
  assign issue_ok  = issue_en && !freeze && !flush && !hazard && !pend_full &&
                     dest_in_range;

  // Per-register write/increment/decrement strobes; decrement at zero is dropped.
  always_comb begin
    wb_sel  = '0;
    cnt_inc = '0;
    cnt_dec = '0;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      wb_sel[r]  = wb_en && (wb_dest == ADDR_W'(r));
      cnt_inc[r] = issue_ok && (issue_dest == ADDR_W'(r));
      cnt_dec[r] = wb_sel[r] && (pend_cnt[r] != CNT_ZERO);
    end
  end

  // Register storage; reset loads each register with its own index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        regs[r] <= DATA_W'(r);
      end
    end else begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        if (wb_sel[r]) begin
          regs[r] <= wb_value;
        end
      end
    end
  end

  // Pending-write counters; simultaneous issue and retire on one register cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        pend_cnt[r] <= CNT_ZERO;
      end
    end else begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        if (cnt_inc[r] && !cnt_dec[r]) begin
          pend_cnt[r] <= pend_cnt[r] + CNT_ONE;
        end else if (cnt_dec[r] && !cnt_inc[r]) begin
          pend_cnt[r] <= pend_cnt[r] - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// tb_id_regfile_scoreboard
//   Directed self-checking bench for id_regfile_scoreboard with 12 registers
//   (so an out-of-range address is expressible) and 4 read ports.

module tb_id_regfile_scoreboard;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 12;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_RD   = 4;
  localparam int unsigned CNT_W    = 2;

  logic                     clk;
  logic                     rst;
  logic                     freeze;
  logic                     flush;
  logic [NUM_RD-1:0]        src_valid;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_dest;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_dest;
  logic [DATA_W-1:0]        wb_value;
  logic                     hazard;
  logic                     pend_full;

  int total = 0;
  int bad   = 0;

  id_regfile_scoreboard #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .src_valid(src_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .issue_en(issue_en), .issue_dest(issue_dest),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .hazard(hazard), .pend_full(pend_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdk(input int k);
    return rd_data[k*DATA_W +: DATA_W];
  endfunction

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Port 0 carries the probed source; ports 1..3 stay idle.
  task automatic src_on(input int a);
    src_valid = 4'b0001;
    rd_addr[3:0] = 4'(a);
  endtask

  task automatic src_off();
    src_valid = 4'b0000;
  endtask

  task automatic wb(input int d, input logic [31:0] v);
    wb_en = 1'b1; wb_dest = 4'(d); wb_value = v;
  endtask

  task automatic wb_off();
    wb_en = 1'b0;
  endtask

  task automatic issue(input int d);
    issue_en = 1'b1; issue_dest = 4'(d);
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    src_valid = '0; rd_addr = {4'd3, 4'd2, 4'd1, 4'd0};
    issue_en = 1'b0; issue_dest = '0;
    wb_en = 1'b0; wb_dest = '0; wb_value = '0;

    // 1. reset contents and idle outputs
    #12;
    chk("rst_rd0", rdk(0), 32'd0);
    chk("rst_rd1", rdk(1), 32'd1);
    chk("rst_rd2", rdk(2), 32'd2);
    chk("rst_rd3", rdk(3), 32'd3);
    chk("rst_hazard", 32'(hazard), 32'd0);
    chk("rst_pend_full", 32'(pend_full), 32'd0);
    rst = 1'b1;
    tick();

    // 2. RAW on r4 resolved by write-back
    issue(4); settle();
    chk("t2_issue_hazard", 32'(hazard), 32'd0);
    tick();
    issue_en = 1'b0; src_on(4); settle();
    chk("t2_raw_hazard", 32'(hazard), 32'd1);
    chk("t2_raw_data", rdk(0), 32'd4);
    wb(4, 32'hA5); settle();
`ifdef REGFILE_BYPASS_EN
    chk("t2_wb_hazard", 32'(hazard), 32'd0);
    chk("t2_wb_data", rdk(0), 32'hA5);
`else
    chk("t2_wb_hazard", 32'(hazard), 32'd1);
    chk("t2_wb_data", rdk(0), 32'd4);
`endif
    tick();
    wb_off(); settle();
    chk("t2_after_hazard", 32'(hazard), 32'd0);
    chk("t2_after_data", rdk(0), 32'hA5);
    src_off();

    // 3. saturation on r5
    for (int i = 0; i < 3; i++) begin
      issue(5); settle();
      chk("t3_issue_nofull", 32'(pend_full), 32'd0);
      tick();
    end
    issue(5); settle();
    chk("t3_full", 32'(pend_full), 32'd1);
    chk("t3_full_hazard", 32'(hazard), 32'd1);
    tick();
    settle();
    chk("t3_still_full", 32'(pend_full), 32'd1);
    issue_en = 1'b0; wb(5, 32'h55);
    tick();
    wb_off(); freeze = 1'b1; issue(5); settle();
    chk("t3_cnt2_nofull", 32'(pend_full), 32'd0);
    freeze = 1'b0;
    tick();
    settle();
    chk("t3_cnt3_full", 32'(pend_full), 32'd1);
    issue_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb(5, 32'h50 + 32'(i));
      tick();
      wb_off(); src_on(5); settle();
      chk("t3_drain_hazard", 32'(hazard), (i < 2) ? 32'd1 : 32'd0);
      src_off();
    end
    src_on(5); settle();
    chk("t3_drain_data", rdk(0), 32'h52);
    src_off();

    // 4. simultaneous issue/retire on r6, retire on idle r7
    issue(6);
    tick();
    issue(6); wb(6, 32'h66);
    tick();
    issue_en = 1'b0; wb_off(); src_on(6); settle();
    chk("t4_cnt1_hazard", 32'(hazard), 32'd1);
    chk("t4_r6_data", rdk(0), 32'h66);
    src_off(); wb(6, 32'h67);
    tick();
    wb_off(); src_on(6); settle();
    chk("t4_cnt0_hazard", 32'(hazard), 32'd0);
    src_off(); wb(7, 32'h77);
    tick();
    wb_off(); src_on(7); settle();
    chk("t4_r7_data", rdk(0), 32'h77);
    chk("t4_r7_hazard", 32'(hazard), 32'd0);
    src_off(); freeze = 1'b1; issue(7); settle();
    chk("t4_r7_nowrap", 32'(pend_full), 32'd0);
    issue_en = 1'b0; freeze = 1'b0;

    // 5. freeze and flush block issue; retire during freeze still applies
    freeze = 1'b1; issue(8);
    tick();
    freeze = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; issue_en = 1'b0; src_on(8); settle();
    chk("t5_blocked_hazard", 32'(hazard), 32'd0);
    src_off(); issue(9);
    tick();
    issue_en = 1'b0; freeze = 1'b1; src_on(9); settle();
    chk("t5_r9_pending", 32'(hazard), 32'd1);
    src_off(); wb(9, 32'h99);
    tick();
    wb_off(); freeze = 1'b0; src_on(9); settle();
    chk("t5_frozen_retire", 32'(hazard), 32'd0);
    chk("t5_r9_data", rdk(0), 32'h99);
    src_off();

    // out-of-range issue destination never counts or fills
    issue(12); settle();
    chk("oor_issue_full", 32'(pend_full), 32'd0);
    issue_en = 1'b0;

    // 6. reset mid-run discards pending state
    issue(10);
    tick();
    issue(11);
    tick();
    issue_en = 1'b0; src_on(10); settle();
    chk("t6_pre_hazard", 32'(hazard), 32'd1);
    rst = 1'b0; settle();
    chk("t6_rst_hazard", 32'(hazard), 32'd0);
    src_on(4); settle();
    chk("t6_rst_r4", rdk(0), 32'd4);
    tick();
    rst = 1'b1;
    src_on(11); settle();
    chk("t6_post_r11_hazard", 32'(hazard), 32'd0);
    src_on(12); settle();
    chk("t6_oor_data", rdk(0), 32'd0);
    chk("t6_oor_hazard", 32'(hazard), 32'd0);
    src_off(); wb(5, 32'hBEEF);
    tick();
    wb_off(); src_on(5); settle();
    chk("t6_wb_zero_data", rdk(0), 32'hBEEF);
    chk("t6_wb_zero_hazard", 32'(hazard), 32'd0);
    src_off();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
